s64x7_bus_arbiter: RTL and testbench
====================================

# s64x7_bus_arbiter

- Two-master, one-slave arbiter for the S64X7 64-bit external bus.
- Shares the memory port between the S64X7 core (master 0: instruction fetch, loads, stores) and one secondary master (master 1: DMA or video).
- Grant parks on the core, so core accesses pass through with zero added latency. Master 1 is granted only while the core's bus cycle is idle.
- An optional watchdog completes cycles that the slave never acknowledges.

## Interface

Parameters:
- TIMEOUT, 255: stalled-cycle limit for the watchdog. Range 1..255. Used only with ARB_TIMEOUT_EN.

Ports (all widths in bits):
- clk_i  in  1  clock; all state changes on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- m0_adr_i  in  [63:3]  core address.
- m0_cyc_i, m0_stb_i, m0_we_i, m0_vpa_i  in  1 each  core cycle, strobe, write enable, instruction-fetch flag.
- m0_sel_i  in  8  core byte lane selects.
- m0_dat_i  in  64  core write data.
- m0_ack_o  out  1  acknowledge to core.
- m0_dat_o  out  64  read data to core.
- m1_adr_i, m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_dat_i  in  same widths as m0; no vpa.
- m1_ack_o  out  1  acknowledge to master 1.
- m1_dat_o  out  64  read data to master 1.
- s_adr_o  out  [63:3]  slave address.
- s_cyc_o, s_stb_o, s_we_o, s_vpa_o  out  1 each  slave cycle, strobe, write enable, fetch flag.
- s_sel_o  out  8  slave byte lane selects.
- s_dat_o  out  64  slave write data.
- s_ack_i  in  1  slave acknowledge.
- s_dat_i  in  64  slave read data.
- gnt_o  out  2  one-hot owner: 01 = core, 10 = master 1.
- to_o  out  1  watchdog-fired pulse.

## Operation

State machine with two registered states:
- GNT0: core owns the bus. This is the reset and park state.
- GNT1: master 1 owns the bus.

Transitions:
- GNT0 to GNT1 when m1_cyc_i=1 and m0_cyc_i=0. Otherwise stay in GNT0.
- GNT1 to GNT0 when m1_cyc_i=0. The core's request does not preempt master 1.
- Ownership never changes while the owner's cyc_i is high. Consecutive core transfers with cyc_i held high therefore starve master 1; this is accepted.

Slave-side outputs:
- s_adr_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o and s_dat_o are a combinational mux of the owner's inputs.
- s_vpa_o = m0_vpa_i in GNT0 and 0 in GNT1.

Master-side outputs:
- Owner's ack_o = s_ack_i.
- Non-owner's ack_o = 0.
- m0_dat_o and m1_dat_o both carry s_dat_i, except during a watchdog completion.

Reset:
- Asserting reset_i forces GNT0, clears the watchdog counter and drives to_o=0, including when it arrives mid-transfer.
- While reset_i=1 the core's signals still pass through, so its reset-vector fetch at $E000_0000_0000_0000 is visible on the slave side.
- m1_ack_o=0 during reset.
- Reset values: gnt_o=01, to_o=0, m1_ack_o=0. All s_* outputs follow m0; s_vpa_o = m0_vpa_i.

## Timing

- Core access: 0 cycles added latency in GNT0. The ack path is combinational.
- Master 1 access: first edge with m1_cyc_i=1 and m0_cyc_i=0 enters GNT1. Its signals reach the slave starting on the following cycle. Minimum 1 cycle added latency.
- Return to core: the edge after m1_cyc_i drops enters GNT0. A core request raised during GNT1 waits, its ack_o held at 0.
- Turnaround cycles drive s_cyc_o = m0_cyc_i (GNT0) or m1_cyc_i (GNT1). No stale owner data is ever presented.

## Configuration

The watchdog is compiled in with ARB_TIMEOUT_EN.

With ARB_TIMEOUT_EN defined:
- An 8-bit counter increments on each edge where s_cyc_o=1, s_stb_o=1 and s_ack_i=0.
- It clears on s_ack_i=1, on s_cyc_o=0, and on reset.
- While the counter equals TIMEOUT and s_ack_i=0, for one cycle:
  - owner's ack_o=1;
  - owner's dat_o = $FFFF_FFFF_FFFF_FFFF;
  - to_o=1;
  - s_cyc_o and s_stb_o are forced to 0;
  - the counter clears on the next edge.
- If s_ack_i=1 in that same cycle, the real ack wins: slave data is returned and to_o=0.

Without ARB_TIMEOUT_EN:
- No counter is built, to_o is tied to 0 and TIMEOUT is ignored.
- A missing ack stalls the owner indefinitely.

## Test plan

- Reset: reset_i=1, m0_cyc_i=1, m0_vpa_i=1, m0_adr_i=$E000_0000_0000_0000 -> s_adr_o=$E000_0000_0000_0000, s_cyc_o=1, s_vpa_o=1, s_sel_o=$FF, gnt_o=01, to_o=0, m1_ack_o=0.
- Contention: m0_cyc_i high for 3 cycles, m1_cyc_i high throughout, m1 write of $0123_4567_89AB_CDEF to $1111_1110 -> m1_ack_o=0 and gnt_o=01 while m0 busy. After m0_cyc_i falls, one edge later: gnt_o=10, s_we_o=1, s_adr_o=$1111_1110, s_dat_o=$0123_4567_89AB_CDEF, s_vpa_o=0. s_ack_i=1 -> m1_ack_o=1, m0_ack_o=0.
- Core waits on master 1: with gnt_o=10, assert m0_cyc_i with vpa=1 -> m0_ack_o=0, s_vpa_o=0. Drop m1_cyc_i -> next edge gnt_o=01, s_vpa_o=1.
- Read routing: core read, s_dat_i=$8100_0000_0000_0000 with s_ack_i=1 -> m0_dat_o=$8100_0000_0000_0000, m0_ack_o=1 in the same cycle.
- Watchdog (ARB_TIMEOUT_EN, TIMEOUT=4): core read, s_ack_i held 0 -> on the 5th cycle m0_ack_o=1, m0_dat_o=$FFFF_FFFF_FFFF_FFFF, to_o=1, s_cyc_o=0. to_o=0 on the following cycle.
- Watchdog tie: same setup with s_ack_i=1 and s_dat_i=$41 in the limit cycle -> m0_dat_o=$41, to_o=0. A reset asserted mid-stall clears the counter, and a new stall needs the full 5 cycles to fire.

Source files
------------

// File: rtl/s64x7_bus_arbiter.sv
// s64x7_bus_arbiter
//   Two-master, one-slave arbiter for the S64X7 64-bit external bus.
//   Master 0 is the core (fetch/load/store) and master 1 is a secondary master (DMA/video).
//   The grant parks on the core, so core accesses pass straight through to the slave
//   with no added latency. Master 1 is granted only while the core's cyc is low, and
//   keeps the bus until it drops its own cyc.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, a watchdog completes any cycle that the slave leaves unacknowledged
//     for TIMEOUT stalled edges. It returns all-ones data and pulses to_o.
//
// Ports
//   clk_i, reset_i                     clock, asynchronous active-high reset
//   m0_* (adr/cyc/stb/we/vpa/sel/dat)  core request; m0_ack_o / m0_dat_o are its responses
//   m1_* (adr/cyc/stb/we/sel/dat)      secondary request; m1_ack_o / m1_dat_o are its responses
//   s_*_o                              muxed request to the slave; s_ack_i / s_dat_i are its responses
//   gnt_o                              one-hot owner (01 core, 10 master 1)
//   to_o                               watchdog-fired pulse (always 0 without ARB_TIMEOUT_EN)

module s64x7_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [63:3]  m0_adr_i,
    input  logic         m0_cyc_i,
    input  logic         m0_stb_i,
    input  logic         m0_we_i,
    input  logic         m0_vpa_i,
    input  logic [7:0]   m0_sel_i,
    input  logic [63:0]  m0_dat_i,
    output logic         m0_ack_o,
    output logic [63:0]  m0_dat_o,
    input  logic [63:3]  m1_adr_i,
    input  logic         m1_cyc_i,
    input  logic         m1_stb_i,
    input  logic         m1_we_i,
    input  logic [7:0]   m1_sel_i,
    input  logic [63:0]  m1_dat_i,
    output logic         m1_ack_o,
    output logic [63:0]  m1_dat_o,
    output logic [63:3]  s_adr_o,
    output logic         s_cyc_o,
    output logic         s_stb_o,
    output logic         s_we_o,
    output logic         s_vpa_o,
    output logic [7:0]   s_sel_o,
    output logic [63:0]  s_dat_o,
    input  logic         s_ack_i,
    input  logic [63:0]  s_dat_i,
    output logic [1:0]   gnt_o,
    output logic         to_o
);

    typedef enum logic [0:0] {
        GNT0 = 1'b0,    // core owns the bus (reset / park state)
        GNT1 = 1'b1     // master 1 owns the bus
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_fire;     // watchdog completes the current cycle

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= GNT0;
        else         r_state <= w_next;
    end

    // Ownership only moves while the current owner's cyc is low; no preemption.
    always_comb begin
        w_next = r_state;
        case (r_state)
            GNT0:    if (m1_cyc_i && !m0_cyc_i) w_next = GNT1;
            GNT1:    if (!m1_cyc_i)             w_next = GNT0;
            default: w_next = GNT0;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    logic [7:0] r_wd_cnt;

    // The counter reads the final (possibly forced) s_cyc_o. In the firing cycle that
    // is 0, so the counter clears on the next edge without a separate term.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                 r_wd_cnt <= 8'd0;
        else if (s_ack_i || !s_cyc_o) r_wd_cnt <= 8'd0;
        else if (s_stb_o)             r_wd_cnt <= r_wd_cnt + 8'd1;
    end

    // A real ack in the limit cycle takes priority over the watchdog.
    assign w_fire = (r_wd_cnt == TO_CNT) && !s_ack_i;
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT);
    assign w_fire = 1'b0;
`endif

    always_comb begin
        gnt_o    = 2'b01;
        s_adr_o  = m0_adr_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        s_vpa_o  = m0_vpa_i;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        to_o     = 1'b0;
        case (r_state)
            GNT1: begin
                gnt_o    = 2'b10;
                s_adr_o  = m1_adr_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                s_vpa_o  = 1'b0;
                m1_ack_o = s_ack_i | w_fire;
                if (w_fire) m1_dat_o = '1;
            end
            default: begin
                m0_ack_o = s_ack_i | w_fire;
                if (w_fire) m0_dat_o = '1;
            end
        endcase
        if (w_fire) begin
            s_cyc_o = 1'b0;
            s_stb_o = 1'b0;
            to_o    = 1'b1;
        end
    end

endmodule

// File: tb/tb_s64x7_bus_arbiter.sv
module tb_s64x7_bus_arbiter;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [63:3]  m0_adr_i;
    logic         m0_cyc_i, m0_stb_i, m0_we_i, m0_vpa_i;
    logic [7:0]   m0_sel_i;
    logic [63:0]  m0_dat_i;
    logic         m0_ack_o;
    logic [63:0]  m0_dat_o;
    logic [63:3]  m1_adr_i;
    logic         m1_cyc_i, m1_stb_i, m1_we_i;
    logic [7:0]   m1_sel_i;
    logic [63:0]  m1_dat_i;
    logic         m1_ack_o;
    logic [63:0]  m1_dat_o;
    logic [63:3]  s_adr_o;
    logic         s_cyc_o, s_stb_o, s_we_o, s_vpa_o;
    logic [7:0]   s_sel_o;
    logic [63:0]  s_dat_o;
    logic         s_ack_i;
    logic [63:0]  s_dat_i;
    logic [1:0]   gnt_o;
    logic         to_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    s64x7_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_vpa_i(m0_vpa_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_adr_i(m1_adr_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_vpa_o(s_vpa_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .gnt_o(gnt_o), .to_o(to_o)
    );

    task automatic idle_all();
        m0_adr_i = '0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_vpa_i = 0;
        m0_sel_i = '0; m0_dat_i = '0;
        m1_adr_i = '0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        m1_sel_i = '0; m1_dat_i = '0;
        s_ack_i = 0; s_dat_i = '0;
    endtask

    task automatic test_reset();
        logic [63:0] a;
        a = 64'hE000_0000_0000_0000;
        @(negedge clk_i);
        reset_i = 1;
        m0_adr_i = a[63:3]; m0_cyc_i = 1; m0_stb_i = 1; m0_vpa_i = 1; m0_sel_i = 8'hFF;
        m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
        #1;
        checks++; if (s_adr_o !== a[63:3]) begin failures++; $display("FAIL reset_s_adr: got %h expected %h", s_adr_o, a[63:3]); end
        checks++; if (s_cyc_o !== 1'b1) begin failures++; $display("FAIL reset_s_cyc: got %b expected 1", s_cyc_o); end
        checks++; if (s_vpa_o !== 1'b1) begin failures++; $display("FAIL reset_s_vpa: got %b expected 1", s_vpa_o); end
        checks++; if (s_sel_o !== 8'hFF) begin failures++; $display("FAIL reset_s_sel: got %h expected ff", s_sel_o); end
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL reset_gnt: got %b expected 01", gnt_o); end
        checks++; if (to_o !== 1'b0) begin failures++; $display("FAIL reset_to: got %b expected 0", to_o); end
        checks++; if (m1_ack_o !== 1'b0) begin failures++; $display("FAIL reset_m1_ack: got %b expected 0", m1_ack_o); end
        // Core idle with m1 requesting across an edge: reset still holds the grant on the core.
        m0_cyc_i = 0; m0_stb_i = 0;
        @(negedge clk_i); #1;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL reset_hold_gnt: got %b expected 01", gnt_o); end
        checks++; if (m1_ack_o !== 1'b0) begin failures++; $display("FAIL reset_hold_m1_ack: got %b expected 0", m1_ack_o); end
        @(negedge clk_i);
        idle_all();
        reset_i = 0;
        @(negedge clk_i);
    endtask

    task automatic test_contention();
        logic [63:0] a;
        a = 64'h0000_0000_1111_1110;
        m0_cyc_i = 1; m0_stb_i = 1; m0_vpa_i = 1; m0_sel_i = 8'h0F;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = a[63:3];
        m1_dat_i = 64'h0123_4567_89AB_CDEF; m1_sel_i = 8'hFF;
        s_ack_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (m1_ack_o !== 1'b0) begin failures++; $display("FAIL cont_m1_ack_busy%0d: got %b expected 0", i, m1_ack_o); end
            checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL cont_gnt_busy%0d: got %b expected 01", i, gnt_o); end
            @(negedge clk_i);
        end
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        #1;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL cont_turn_gnt: got %b expected 01", gnt_o); end
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL cont_turn_s_cyc: got %b expected 0", s_cyc_o); end
        @(negedge clk_i); #1;
        checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL cont_gnt1: got %b expected 10", gnt_o); end
        checks++; if (s_we_o !== 1'b1) begin failures++; $display("FAIL cont_s_we: got %b expected 1", s_we_o); end
        checks++; if (s_adr_o !== a[63:3]) begin failures++; $display("FAIL cont_s_adr: got %h expected %h", s_adr_o, a[63:3]); end
        checks++; if (s_dat_o !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL cont_s_dat: got %h expected 0123456789abcdef", s_dat_o); end
        checks++; if (s_vpa_o !== 1'b0) begin failures++; $display("FAIL cont_s_vpa: got %b expected 0", s_vpa_o); end
        checks++; if (s_sel_o !== 8'hFF) begin failures++; $display("FAIL cont_s_sel: got %h expected ff", s_sel_o); end
        s_ack_i = 1; s_dat_i = 64'h5A5A_0000_1234_0001;
        #1;
        checks++; if (m1_ack_o !== 1'b1) begin failures++; $display("FAIL cont_m1_ack: got %b expected 1", m1_ack_o); end
        checks++; if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL cont_m0_ack: got %b expected 0", m0_ack_o); end
        checks++; if (m1_dat_o !== 64'h5A5A_0000_1234_0001) begin failures++; $display("FAIL cont_m1_dat: got %h expected 5a5a000012340001", m1_dat_o); end
        @(negedge clk_i);
    endtask

    task automatic test_core_waits();
        logic [63:0] a;
        a = 64'h0000_0000_0000_2000;
        m0_cyc_i = 1; m0_stb_i = 1; m0_vpa_i = 1; m0_adr_i = a[63:3];
        s_ack_i = 1;
        #1;
        checks++; if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL wait_m0_ack: got %b expected 0", m0_ack_o); end
        checks++; if (s_vpa_o !== 1'b0) begin failures++; $display("FAIL wait_s_vpa: got %b expected 0", s_vpa_o); end
        @(negedge clk_i);
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        #1;
        checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL wait_gnt_before_edge: got %b expected 10", gnt_o); end
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL wait_turn_s_cyc: got %b expected 0", s_cyc_o); end
        @(negedge clk_i); #1;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL wait_gnt0: got %b expected 01", gnt_o); end
        checks++; if (s_vpa_o !== 1'b1) begin failures++; $display("FAIL wait_s_vpa_back: got %b expected 1", s_vpa_o); end
        checks++; if (s_adr_o !== a[63:3]) begin failures++; $display("FAIL wait_s_adr: got %h expected %h", s_adr_o, a[63:3]); end
        @(negedge clk_i);
        idle_all();
        @(negedge clk_i);
    endtask

    task automatic test_read();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
        s_dat_i = 64'h8100_0000_0000_0000; s_ack_i = 1;
        #1;
        checks++; if (m0_dat_o !== 64'h8100_0000_0000_0000) begin failures++; $display("FAIL read_m0_dat: got %h expected 8100000000000000", m0_dat_o); end
        checks++; if (m0_ack_o !== 1'b1) begin failures++; $display("FAIL read_m0_ack: got %b expected 1", m0_ack_o); end
        checks++; if (m1_ack_o !== 1'b0) begin failures++; $display("FAIL read_m1_ack: got %b expected 0", m1_ack_o); end
        checks++; if (s_we_o !== 1'b0) begin failures++; $display("FAIL read_s_we: got %b expected 0", s_we_o); end
        @(negedge clk_i);
        idle_all();
        @(negedge clk_i);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_watchdog();
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 0; s_dat_i = 64'h1234;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (to_o !== 1'b0 || m0_ack_o !== 1'b0) begin failures++; $display("FAIL wd_early%0d: got to=%b ack=%b expected 0 0", i, to_o, m0_ack_o); end
            @(negedge clk_i);
        end
        #1;
        checks++; if (m0_ack_o !== 1'b1) begin failures++; $display("FAIL wd_ack: got %b expected 1", m0_ack_o); end
        checks++; if (m0_dat_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL wd_dat: got %h expected ffffffffffffffff", m0_dat_o); end
        checks++; if (to_o !== 1'b1) begin failures++; $display("FAIL wd_to: got %b expected 1", to_o); end
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin failures++; $display("FAIL wd_s_cyc: got cyc=%b stb=%b expected 0 0", s_cyc_o, s_stb_o); end
        @(negedge clk_i); #1;
        checks++; if (to_o !== 1'b0) begin failures++; $display("FAIL wd_to_after: got %b expected 0", to_o); end
        checks++; if (s_cyc_o !== 1'b1) begin failures++; $display("FAIL wd_s_cyc_after: got %b expected 1", s_cyc_o); end
        @(negedge clk_i);
        idle_all();
        @(negedge clk_i);
    endtask

    task automatic test_watchdog_tie();
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 0;
        repeat (4) @(negedge clk_i);
        s_ack_i = 1; s_dat_i = 64'h41;
        #1;
        checks++; if (m0_dat_o !== 64'h41) begin failures++; $display("FAIL tie_dat: got %h expected 41", m0_dat_o); end
        checks++; if (to_o !== 1'b0) begin failures++; $display("FAIL tie_to: got %b expected 0", to_o); end
        checks++; if (m0_ack_o !== 1'b1) begin failures++; $display("FAIL tie_ack: got %b expected 1", m0_ack_o); end
        @(negedge clk_i);
        idle_all();
        @(negedge clk_i);
        // Stall three edges, reset for one, then the full five cycles are needed again.
        m0_cyc_i = 1; m0_stb_i = 1;
        repeat (3) @(negedge clk_i);
        reset_i = 1;
        #1;
        checks++; if (to_o !== 1'b0) begin failures++; $display("FAIL tie_rst_to: got %b expected 0", to_o); end
        @(negedge clk_i);
        reset_i = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (to_o !== 1'b0) begin failures++; $display("FAIL tie_post_rst_early%0d: got %b expected 0", i, to_o); end
            @(negedge clk_i);
        end
        #1;
        checks++; if (to_o !== 1'b1 || m0_ack_o !== 1'b1) begin failures++; $display("FAIL tie_post_rst_fire: got to=%b ack=%b expected 1 1", to_o, m0_ack_o); end
        @(negedge clk_i);
        idle_all();
        @(negedge clk_i);
    endtask
`else
    task automatic test_no_watchdog();
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (to_o !== 1'b0 || m0_ack_o !== 1'b0 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL nowd_stall%0d: got to=%b ack=%b cyc=%b expected 0 0 1", i, to_o, m0_ack_o, s_cyc_o); end
            @(negedge clk_i);
        end
        idle_all();
        @(negedge clk_i);
    endtask
`endif

    initial begin
        reset_i = 0;
        idle_all();
        test_reset();
        test_contention();
        test_core_waits();
        test_read();
`ifdef ARB_TIMEOUT_EN
        test_watchdog();
        test_watchdog_tie();
`else
        test_no_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
